color_manager_raster_counter: RTL and testbench
===============================================

# color_manager_raster_counter

Two-dimensional raster position generator for the Color_Manager pipeline. It takes the horizontal and vertical sync windows and programmable porches, and produces a qualified pixel-valid strobe, active-area X/Y coordinates, line/frame start pulses and a sticky overflow flag. It sits between sync decode and the colour generators and replaces the single-axis porch counter.

## Interface
- H_WIDTH, 12, width of horizontal counters, porches and PixelX
- V_WIDTH, 11, width of vertical counters, porches and PixelY
- SYNC_POL, 1, 1 means the sync window is active-high; 0 means both sync inputs are inverted internally before use
- Clk  in  1  single clock; all logic on rising edge
- Rst  in  1  asynchronous, active-high reset
- HSync  in  1  line window (high for the duration of a line when SYNC_POL=1)
- VSync  in  1  frame window
- HBackPorch  in  H_WIDTH  last horizontal count excluded before the active area
- HFrontPorch  in  H_WIDTH  first horizontal count excluded after the active area
- VBackPorch  in  V_WIDTH  vertical equivalent of HBackPorch
- VFrontPorch  in  V_WIDTH  vertical equivalent of HFrontPorch
- Err_Clr  in  1  synchronous clear of Overflow
- Pixel_Valid  out  1  current cycle is an active pixel
- PixelX  out  H_WIDTH  active-area column, 0-based
- PixelY  out  V_WIDTH  active-area row, 0-based
- Line_Start  out  1  one-cycle pulse on the first valid pixel of each line
- Frame_Start  out  1  one-cycle pulse on the first valid pixel of each frame
- Overflow  out  1  sticky; a counter saturated

## Operation
- hs and vs are the polarity-corrected syncs. hs_d is hs registered, used for fall detection.
- Shadow porches: all four porch inputs are captured into shadow registers on every cycle with vs=0 and held while vs=1. Mid-frame porch changes have no effect until the next frame. All compares use the shadow values.
- hcnt: forced to 0 when hs=0. Otherwise it increments each cycle and saturates at all-ones.
- h_act is true when shadow HBP < hcnt < shadow HFP, using strict compares.
- vcnt: forced to 0 when vs=0. Otherwise it increments once on each hs falling edge (hs_d=1, hs=0) and saturates at all-ones. vs=0 takes priority over a simultaneous hs fall.
- v_act is true when shadow VBP < vcnt < shadow VFP.
- Active pixels per line = max(0, HFP−HBP−1). Active lines per frame = max(0, VFP−VBP−1).
- Pixel_Valid next = hs & h_act & vs & v_act. It is cleared when hs=0 or vs=0.
- PixelX next = hcnt−HBP−1 when valid, else 0. PixelY next = vcnt−VBP−1 when valid, else 0. Both are truncated to the port width.
- Line_Start next = valid next & (PixelX next == 0). Frame_Start additionally requires PixelY next == 0.
- Overflow is set when hcnt is all-ones with hs=1, or when vcnt is all-ones at an hs fall with vs=1. It is cleared by Err_Clr; set wins over a simultaneous clear.
- If porches are set with HFP ≤ HBP+1, the line has no valid pixels and no Line_Start.

## Timing
- All outputs are registered. Reset value of every output and internal register, including the shadows, is 0.
- Latency: Pixel_Valid asserts on the edge where pre-edge hcnt = HBP+1. With hs sampled high from edge 0, hcnt = n+1 after edge n, so the first valid cycle follows edge HBP+1.
- hs fall: Pixel_Valid and PixelX go to 0 on that same edge. No extra valid cycle is allowed.
- Reset mid-operation: outputs drop to 0 immediately. Shadows are 0, so no valid output appears until a vs=0 cycle reloads the porches.
- Counter wrap is never allowed; both counters saturate.

## Structure
- Shared package color_manager_pkg holds:
  - the default H_WIDTH/V_WIDTH constants;
  - a porch-set struct type {back, front};
  - a polarity-correction function.
- One sub-module, color_manager_window_count, is instantiated twice (H and V). It is parameterised by width and provides:
  - inputs: window, increment enable, shadow load, porch pair;
  - outputs: count, active flag, offset (count−back−1), saturate flag.
- The top level holds hs_d, the output registers and the Overflow logic.

## Test plan
- Porches: HBP=2, HFP=7, VBP=1, VFP=4. Lines 10 cycles high with 2-cycle gaps; VSync high for 6 lines.
  - Required: 2 active lines; each line gives 4 valid cycles with PixelX 0..3.
  - PixelY is 0 then 1. Line_Start fires 2 times and Frame_Start fires 1 time.
- Change HFP to 9 while VSync=1.
  - Required: the current frame keeps 4 pixels per line; the next frame gives 6.
- hs=0 pulse for 1 cycle mid-active (HBP=2, HFP=20).
  - Required: Pixel_Valid falls on that edge, then restarts with PixelX=0 after HBP+1 edges.
- H_WIDTH=4, HSync held high for 20 cycles.
  - Required: Overflow=1 and hcnt is stuck at 15.
  - Err_Clr with HSync low clears it. Err_Clr and a saturate event in the same cycle keeps Overflow=1.
- Assert Rst mid-line.
  - Required: all outputs are 0 within the same cycle.
  - After release, no Pixel_Valid until a VSync-low cycle has occurred.
- SYNC_POL=0 with inverted stimulus of the first scenario.
  - Required: identical output sequence.

Source files
------------

// File: rtl/color_manager_pkg.sv
// Shared types and helpers for the Color_Manager raster position logic.
// Porch pairs travel as a fixed-width struct; narrower counters zero-extend into it.
package color_manager_pkg;

  localparam int H_WIDTH_DEF = 12;
  localparam int V_WIDTH_DEF = 11;
  localparam int PORCH_W     = 16;

  typedef struct packed {
    logic [PORCH_W-1:0] back;
    logic [PORCH_W-1:0] front;
  } porch_set_t;

  function automatic logic sync_correct(input logic sync, input logic pol);
    return pol ? sync : ~sync;
  endfunction

endpackage

// File: rtl/color_manager_window_count.sv
// One raster axis: shadowed porch pair, saturating window counter and the
// strict back < count < front active test with the 0-based active offset.
module color_manager_window_count
  import color_manager_pkg::*;
#(
  parameter int W = H_WIDTH_DEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         window,
  input  logic         inc_en,
  input  logic         load,
  input  porch_set_t   porch,
  output logic [W-1:0] count,
  output logic         active,
  output logic [W-1:0] offset,
  output logic         sat
);

  porch_set_t         shadow;
  logic [PORCH_W-1:0] count_ext;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadow <= '0;
    end else if (load) begin
      shadow <= porch;
    end
  end

  // Closing the window always wins; otherwise count up and stick at all-ones.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (!window) begin
      count <= '0;
    end else if (inc_en && !sat) begin
      count <= count + W'(1);
    end
  end

  assign sat       = &count;
  assign count_ext = PORCH_W'(count);
  assign active    = (shadow.back < count_ext) && (count_ext < shadow.front);
  assign offset    = W'(count_ext - shadow.back - PORCH_W'(1));

endmodule

// File: rtl/color_manager_raster_counter.sv
// Raster position generator: H/V window counters plus registered pixel strobe,
// active-area coordinates, line/frame start pulses and a sticky overflow flag.
module color_manager_raster_counter
  import color_manager_pkg::*;
#(
  parameter int H_WIDTH  = H_WIDTH_DEF,
  parameter int V_WIDTH  = V_WIDTH_DEF,
  parameter bit SYNC_POL = 1'b1
) (
  input  logic               Clk,
  input  logic               Rst,
  input  logic               HSync,
  input  logic               VSync,
  input  logic [H_WIDTH-1:0] HBackPorch,
  input  logic [H_WIDTH-1:0] HFrontPorch,
  input  logic [V_WIDTH-1:0] VBackPorch,
  input  logic [V_WIDTH-1:0] VFrontPorch,
  input  logic               Err_Clr,
  output logic               Pixel_Valid,
  output logic [H_WIDTH-1:0] PixelX,
  output logic [V_WIDTH-1:0] PixelY,
  output logic               Line_Start,
  output logic               Frame_Start,
  output logic               Overflow
);

  logic               hs, vs, hs_d, hs_fall;
  porch_set_t         h_porch, v_porch;
  logic [H_WIDTH-1:0] h_count, h_off;
  logic [V_WIDTH-1:0] v_count, v_off;
  logic               h_act, v_act, h_sat, v_sat;
  logic               valid_nx, line_nx, frame_nx, ovf_set;
  logic [H_WIDTH-1:0] x_nx;
  logic [V_WIDTH-1:0] y_nx;

  assign hs      = sync_correct(HSync, SYNC_POL);
  assign vs      = sync_correct(VSync, SYNC_POL);
  assign hs_fall = hs_d & ~hs;

  assign h_porch.back  = PORCH_W'(HBackPorch);
  assign h_porch.front = PORCH_W'(HFrontPorch);
  assign v_porch.back  = PORCH_W'(VBackPorch);
  assign v_porch.front = PORCH_W'(VFrontPorch);

  // Porches are only sampled outside the frame window so a frame is self-consistent.
  color_manager_window_count #(.W(H_WIDTH)) u_h_count (
    .clk    (Clk),
    .rst    (Rst),
    .window (hs),
    .inc_en (1'b1),
    .load   (~vs),
    .porch  (h_porch),
    .count  (h_count),
    .active (h_act),
    .offset (h_off),
    .sat    (h_sat)
  );

  color_manager_window_count #(.W(V_WIDTH)) u_v_count (
    .clk    (Clk),
    .rst    (Rst),
    .window (vs),
    .inc_en (hs_fall),
    .load   (~vs),
    .porch  (v_porch),
    .count  (v_count),
    .active (v_act),
    .offset (v_off),
    .sat    (v_sat)
  );

  // Pixel_Valid is a pure strobe: no backpressure, consumers must take each valid cycle.
  assign valid_nx = hs & h_act & vs & v_act;
  assign x_nx     = valid_nx ? h_off : '0;
  assign y_nx     = valid_nx ? v_off : '0;
  assign line_nx  = valid_nx & (x_nx == '0);
  assign frame_nx = line_nx & (y_nx == '0);
  assign ovf_set  = (h_sat & hs) | (v_sat & hs_fall & vs);

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      hs_d        <= 1'b0;
      Pixel_Valid <= 1'b0;
      PixelX      <= '0;
      PixelY      <= '0;
      Line_Start  <= 1'b0;
      Frame_Start <= 1'b0;
      Overflow    <= 1'b0;
    end else begin
      hs_d        <= hs;
      Pixel_Valid <= valid_nx;
      PixelX      <= x_nx;
      PixelY      <= y_nx;
      Line_Start  <= line_nx;
      Frame_Start <= frame_nx;
      Overflow    <= ovf_set | (Overflow & ~Err_Clr);
    end
  end

endmodule

// File: tb/tb_color_manager_raster_counter.sv
// Bench for color_manager_raster_counter: a normal-polarity DUT and an
// inverted-polarity DUT share one scoreboard stream; a 4-bit DUT covers overflow.
module tb_color_manager_raster_counter;
  import color_manager_pkg::*;

  localparam int HW = 12;
  localparam int VW = 11;
  localparam int SW = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          hsync, vsync, err_clr;
  logic [HW-1:0] hbp, hfp;
  logic [VW-1:0] vbp, vfp;
  logic          hsync_s, err_clr_s;
  logic          mon_en;

  logic          pv_m, ls_m, fs_m, ov_m;
  logic [HW-1:0] px_m;
  logic [VW-1:0] py_m;
  logic          pv_i, ls_i, fs_i, ov_i;
  logic [HW-1:0] px_i;
  logic [VW-1:0] py_i;
  logic          pv_s, ls_s, fs_s, ov_s;
  logic [SW-1:0] px_s;
  logic [VW-1:0] py_s;

  color_manager_raster_counter #(.H_WIDTH(HW), .V_WIDTH(VW), .SYNC_POL(1'b1)) u_main (
    .Clk(clk), .Rst(rst), .HSync(hsync), .VSync(vsync),
    .HBackPorch(hbp), .HFrontPorch(hfp), .VBackPorch(vbp), .VFrontPorch(vfp),
    .Err_Clr(err_clr), .Pixel_Valid(pv_m), .PixelX(px_m), .PixelY(py_m),
    .Line_Start(ls_m), .Frame_Start(fs_m), .Overflow(ov_m)
  );

  color_manager_raster_counter #(.H_WIDTH(HW), .V_WIDTH(VW), .SYNC_POL(1'b0)) u_inv (
    .Clk(clk), .Rst(rst), .HSync(~hsync), .VSync(~vsync),
    .HBackPorch(hbp), .HFrontPorch(hfp), .VBackPorch(vbp), .VFrontPorch(vfp),
    .Err_Clr(err_clr), .Pixel_Valid(pv_i), .PixelX(px_i), .PixelY(py_i),
    .Line_Start(ls_i), .Frame_Start(fs_i), .Overflow(ov_i)
  );

  color_manager_raster_counter #(.H_WIDTH(SW), .V_WIDTH(VW), .SYNC_POL(1'b1)) u_small (
    .Clk(clk), .Rst(rst), .HSync(hsync_s), .VSync(1'b0),
    .HBackPorch(4'd2), .HFrontPorch(4'd7), .VBackPorch(11'd1), .VFrontPorch(11'd4),
    .Err_Clr(err_clr_s), .Pixel_Valid(pv_s), .PixelX(px_s), .PixelY(py_s),
    .Line_Start(ls_s), .Frame_Start(fs_s), .Overflow(ov_s)
  );

  // ---------------- scoreboard ----------------
  logic [31:0] exp_q[$];
  logic [31:0] exp_qi[$];
  int checks   = 0;
  int failures = 0;

  function automatic logic [31:0] pack(int x, int y, bit ls, bit fs);
    logic [11:0] xs;
    logic [10:0] ys;
    xs = x[11:0];
    ys = y[10:0];
    return {7'd0, fs, ls, ys, xs};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic push_line(input int y, input int n);
    for (int x = 0; x < n; x++) begin
      exp_q.push_back(pack(x, y, x == 0, (x == 0) && (y == 0)));
      exp_qi.push_back(pack(x, y, x == 0, (x == 0) && (y == 0)));
    end
  endtask

  // ---------------- monitors ----------------
  always @(posedge clk) begin
    #1;
    if (mon_en) begin
      if (pv_m === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL main_extra_pixel actual=%h required=none", {7'd0, fs_m, ls_m, py_m, px_m});
        end else begin
          check("main_pixel", {7'd0, fs_m, ls_m, py_m, px_m}, exp_q.pop_front());
        end
      end else begin
        check("main_idle", {8'd0, fs_m, ls_m, py_m, px_m}, 32'd0);
      end
    end
  end

  always @(posedge clk) begin
    #1;
    if (mon_en) begin
      if (pv_i === 1'b1) begin
        if (exp_qi.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL inv_extra_pixel actual=%h required=none", {7'd0, fs_i, ls_i, py_i, px_i});
        end else begin
          check("inv_pixel", {7'd0, fs_i, ls_i, py_i, px_i}, exp_qi.pop_front());
        end
      end else begin
        check("inv_idle", {8'd0, fs_i, ls_i, py_i, px_i}, 32'd0);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive(input logic h, input logic v, input int n);
    hsync = h;
    vsync = v;
    repeat (n) @(negedge clk);
  endtask

  task automatic run_line(input int n_high);
    drive(1'b1, 1'b1, n_high);
    drive(1'b0, 1'b1, 2);
  endtask

  task automatic run_frame(input int n_lines);
    drive(1'b0, 1'b0, 3);
    repeat (n_lines) run_line(10);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_main"}, {26'd0, pv_m, ls_m, fs_m, ov_m} | {8'd0, py_m, px_m}, 32'd0);
    check({tag, "_inv"},  {26'd0, pv_i, ls_i, fs_i, ov_i} | {8'd0, py_i, px_i}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    mon_en    = 1'b0;
    rst       = 1'b1;
    hsync     = 1'b0;
    vsync     = 1'b0;
    err_clr   = 1'b0;
    hsync_s   = 1'b0;
    err_clr_s = 1'b0;
    hbp = 12'd2; hfp = 12'd7; vbp = 11'd1; vfp = 11'd4;
    repeat (3) @(negedge clk);
    check_outputs_zero("reset_state");
    check("reset_small_ovf", {31'd0, ov_s}, 32'd0);
    rst    = 1'b0;
    mon_en = 1'b1;

    // Basic frame: 2 active lines x 4 pixels
    push_line(0, 4);
    push_line(1, 4);
    run_frame(6);

    // HFP changed mid-frame: this frame stays at 4 pixels, next frame gives 6
    push_line(0, 4);
    push_line(1, 4);
    drive(1'b0, 1'b0, 3);
    run_line(10);
    hfp = 12'd9;
    repeat (5) run_line(10);
    push_line(0, 6);
    push_line(1, 6);
    run_frame(6);

    // One-cycle hs drop mid-active; the drop is also an hs fall for vcnt
    hfp = 12'd20;
    push_line(0, 5);
    push_line(1, 7);
    drive(1'b0, 1'b0, 3);
    run_line(10);
    run_line(10);
    drive(1'b1, 1'b1, 8);
    drive(1'b0, 1'b1, 1);
    drive(1'b1, 1'b1, 10);
    drive(1'b0, 1'b1, 2);

    // Reset mid-line, then no pixels until VSync drops again
    hfp = 12'd7;
    push_line(0, 3);
    drive(1'b0, 1'b0, 3);
    run_line(10);
    run_line(10);
    drive(1'b1, 1'b1, 6);
    rst = 1'b1;
    #1;
    check_outputs_zero("reset_midline");
    repeat (2) @(negedge clk);
    rst = 1'b0;
    run_line(10);
    run_line(10);
    run_line(10);
    push_line(0, 4);
    push_line(1, 4);
    run_frame(6);
    drive(1'b0, 1'b0, 4);
    check("main_queue_empty", exp_q.size(), 32'd0);
    check("inv_queue_empty", exp_qi.size(), 32'd0);

    // 4-bit horizontal counter saturation and sticky overflow
    hsync_s = 1'b1;
    repeat (20) @(negedge clk);
    check("small_ovf_set", {31'd0, ov_s}, 32'd1);
    check("small_hcnt_stuck", {28'd0, u_small.u_h_count.count}, 32'd15);
    hsync_s   = 1'b0;
    err_clr_s = 1'b1;
    @(negedge clk);
    err_clr_s = 1'b0;
    check("small_ovf_cleared", {31'd0, ov_s}, 32'd0);
    hsync_s = 1'b1;
    repeat (15) @(negedge clk);
    check("small_ovf_not_yet", {31'd0, ov_s}, 32'd0);
    check("small_hcnt_full", {28'd0, u_small.u_h_count.count}, 32'd15);
    err_clr_s = 1'b1;
    @(negedge clk);
    err_clr_s = 1'b0;
    check("small_ovf_set_wins", {31'd0, ov_s}, 32'd1);
    check("main_no_ovf", {30'd0, ov_m, ov_i}, 32'd0);
    hsync_s = 1'b0;
    repeat (2) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
